adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pkg.sv | 12 +
 rtl/adder_seg.sv | 23 ++
 rtl/adder_pipe.sv | 143 ++++++++++++++
 tb/tb_adder_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared defaults and mode encoding for the segmented pipelined adder.
package adder_pkg;

  localparam int ADDER_WIDTH_DEF  = 32;
  localparam int ADDER_STAGES_DEF = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/adder_seg.sv
// One SEG-bit ripple segment of the pipelined adder.
module adder_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] s_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  logic [SEG:0] sum;

  always_comb begin
    sum    = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
    s_o    = sum[SEG-1:0];
    cout_o = sum[SEG];
    // carry into the top bit recovered from its sum bit
    cmsb_o = a_i[SEG-1] ^ b_i[SEG-1] ^ sum[SEG-1];
  end

endmodule

// File: rtl/adder_pipe.sv
// Carry-segmented pipelined add/subtract unit with valid/ready flow
// control; every stage stalls together when the output is blocked.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH_DEF,
  parameter int STAGES = ADDER_STAGES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("adder_pipe: illegal WIDTH/STAGES combination");
  end

  logic             v_q   [STAGES];
  logic             v_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic [SEG-1:0]   seg_s [STAGES];
  logic             seg_co[STAGES];
  logic             seg_cm[STAGES];

  mode_e            mode;
  logic [WIDTH-1:0] b_eff;
  logic             advance;

  always_comb begin
    mode     = mode_e'(sub_i);
    b_eff    = (mode == SUB) ? ~b_i : b_i;
    advance  = ~v_q[STAGES-1] | ready_i;
    src_v[0] = valid_i;
    src_a[0] = a_i;
    src_b[0] = b_eff;
    src_s[0] = '0;
    src_c[0] = cin_i ^ sub_i;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_seg #(
      .SEG(SEG)
    ) u_seg (
      .a_i   (src_a[k][k*SEG +: SEG]),
      .b_i   (src_b[k][k*SEG +: SEG]),
      .cin_i (src_c[k]),
      .s_o   (seg_s[k]),
      .cout_o(seg_co[k]),
      .cmsb_o(seg_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = v_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      if (advance) begin
        v_d[k]               = src_v[k];
        a_d[k]               = src_a[k];
        b_d[k]               = src_b[k];
        s_d[k]               = src_s[k];
        s_d[k][k*SEG +: SEG] = seg_s[k];
        c_d[k]               = seg_co[k];
      end
    end
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (advance) begin
      ovf_d  = seg_cm[STAGES-1] ^ seg_co[STAGES-1];
      zero_d = (s_d[STAGES-1] == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign ready_o = advance;
  assign valid_o = v_q[STAGES-1];
  assign s_o     = s_q[STAGES-1];
  assign cout_o  = c_q[STAGES-1];
  assign ovf_o   = ovf_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe at 4, 1 and 8 stages.
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_i, cin_i, sub_i;
  logic [31:0] a_i, b_i;

  logic        rdy4, v4, co4, ov4, z4;
  logic [31:0] s4;
  logic        rdy1, v1, co1, ov1, z1;
  logic [31:0] s1;
  logic        rdy8, v8, co8, ov8, z8;
  logic [31:0] s8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(32), .STAGES(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy4),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sub_i(sub_i),
    .valid_o(v4), .ready_i(ready_i), .s_o(s4), .cout_o(co4),
    .ovf_o(ov4), .zero_o(z4)
  );

  adder_pipe #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy1),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sub_i(sub_i),
    .valid_o(v1), .ready_i(ready_i), .s_o(s1), .cout_o(co1),
    .ovf_o(ov1), .zero_o(z1)
  );

  adder_pipe #(.WIDTH(32), .STAGES(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy8),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sub_i(sub_i),
    .valid_o(v8), .ready_i(ready_i), .s_o(s8), .cout_o(co8),
    .ovf_o(ov8), .zero_o(z8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exp packs {cout, ovf, zero, s}
  task automatic op_check(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic sub,
                          input logic cin, input logic [34:0] exp);
    int l4 = -1, l1 = -1, l8 = -1;
    logic [34:0] r4 = '0, r1 = '0, r8 = '0;
    ready_i = 1'b1;
    valid_i = 1'b1;
    a_i = a; b_i = b; sub_i = sub; cin_i = cin;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) valid_i = 1'b0;
      if (v4 && l4 < 0) begin l4 = c; r4 = {co4, ov4, z4, s4}; end
      if (v1 && l1 < 0) begin l1 = c; r1 = {co1, ov1, z1, s1}; end
      if (v8 && l8 < 0) begin l8 = c; r8 = {co8, ov8, z8, s8}; end
    end
    chk({tag, "_res4"}, 64'(r4), 64'(exp));
    chk({tag, "_lat4"}, 64'(l4), 64'd4);
    chk({tag, "_res1"}, 64'(r1), 64'(exp));
    chk({tag, "_lat1"}, 64'(l1), 64'd1);
    chk({tag, "_res8"}, 64'(r8), 64'(exp));
    chk({tag, "_lat8"}, 64'(l8), 64'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sa [10];
    logic [31:0] sb [10];
    logic        ss [10];
    logic [31:0] es [10];
    logic [31:0] prev_s;
    logic        hold;
    int          nin, nout, low, extra;

    rst = 1'b1;
    valid_i = 1'b0; ready_i = 1'b1;
    a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
    #3;
    chk("rst_out4", 64'({v4, s4, co4, ov4, z4}), 64'd0);
    chk("rst_out1", 64'({v1, s1, co1, ov1, z1}), 64'd0);
    chk("rst_out8", 64'({v8, s8, co8, ov8, z8}), 64'd0);
    chk("rst_rdy", 64'({rdy4, rdy1, rdy8}), 64'b111);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_rdy", 64'({rdy4, rdy1, rdy8}), 64'b111);
    @(posedge clk); #1;

    op_check("add_1_2",   32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0,
             {3'b000, 32'h0000_0003});
    op_check("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             {3'b101, 32'h0000_0000});
    op_check("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             {3'b010, 32'h8000_0000});
    op_check("sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0,
             {3'b000, 32'hFFFF_FFFE});
    op_check("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
             {3'b110, 32'h7FFF_FFFF});
    op_check("sub_borrow", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1,
             {3'b100, 32'h0000_0006});
    op_check("add_cin",   32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1,
             {3'b000, 32'h0001_0000});
    op_check("sub_zero",  32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0,
             {3'b101, 32'h0000_0000});

    for (int i = 0; i < 10; i++) begin
      sa[i] = 32'h0102_0304 * (i + 1);
      sb[i] = 32'h00FF_00FF + 32'(i);
      ss[i] = i[0];
      es[i] = ss[i] ? sa[i] - sb[i] : sa[i] + sb[i];
    end
    nin = 0; nout = 0; low = 0; hold = 1'b0; prev_s = '0;
    for (int c = 0; c < 60 && nout < 10; c++) begin
      ready_i = !(c >= 6 && c < 9);
      cin_i = 1'b0;
      if (nin < 10) begin
        valid_i = 1'b1;
        a_i = sa[nin]; b_i = sb[nin]; sub_i = ss[nin];
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (!rdy4) low++;
      if (hold) chk($sformatf("stall_hold_c%0d", c), 64'(s4), 64'(prev_s));
      hold = v4 && !ready_i;
      prev_s = s4;
      if (v4 && ready_i) begin
        chk($sformatf("stream_out%0d", nout), 64'(s4), 64'(es[nout]));
        nout++;
      end
      if (valid_i && rdy4) nin++;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (v4) extra++;
      @(posedge clk); #1;
    end
    chk("stream_in_cnt", 64'(nin), 64'd10);
    chk("stream_out_cnt", 64'(nout), 64'd10);
    chk("stream_rdy_low", 64'(low), 64'd3);
    chk("stream_extra", 64'(extra), 64'd0);

    valid_i = 1'b1; sub_i = 1'b0; cin_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_i = 32'h1111_0000 + 32'(i);
      b_i = 32'h0000_2222;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out4", 64'({v4, s4, co4, ov4, z4}), 64'd0);
    chk("midrst_rdy4", 64'(rdy4), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (v4 || v1 || v8) extra++;
    end
    chk("midrst_no_stale", 64'(extra), 64'd0);
    op_check("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
             {3'b000, 32'h2345_6789});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
